cntr_req_sched: RTL and testbench
=================================

// Module: cntr_req_sched
// PURPOSE
//  Counter-request scheduler for the memory-cycle timer. Latches PINC/MINC increment
//  requests from up to NCELLS counter cells and grants one cell per memory cycle time
//  (MCT, T01..T12). The grant is always the lowest-index pending cell. It sits between
//  the counter-cell request lines and the sequence generator, paced by the timer's
//  T12/GOJAM/STOP outputs.
// PARAMETERS
//  NCELLS  20  number of counter cells; cell 0 has the highest priority
//  IDXW    5   width of the granted-cell index; must satisfy 2**IDXW >= NCELLS
// PORTS
//  SIM_CLK    in   1       simulation clock; the only clock
//  SIM_RST    in   1       synchronous reset, active-high
//  T12        in   1       timer pulse level; its rising edge ends an MCT (multi-clock level)
//  GOJAM      in   1       restart; level
//  STOP       in   1       timer stopped; level, freezes new grants
//  REQ_PLUS   in   NCELLS  per-cell +1 request; level pulses
//  REQ_MINUS  in   NCELLS  per-cell -1 request; level pulses
//  CNT_GRANT  out  NCELLS  one-hot cell served in the current MCT (0 = none)
//  CNT_IDX    out  IDXW    binary index of the granted cell; 0 when no grant
//  CNT_DIR    out  1       1 = minus (MINC), 0 = plus (PINC); valid while CNT_GRANT != 0
//  CNT_ACTIVE out  1       OR of CNT_GRANT
//  PEND_ANY   out  1       at least one cell pending (combinational from pending regs)
//  CNT_LOST   out  1       one-clock pulse when a request edge hits an already-pending same-direction bit
// BEHAVIOUR
//  - Reset: pend_p, pend_m, the grant register and the edge-detect history are all cleared.
//    Every output is 0 on the first clock after reset.
//  - Edge detect: the block registers T12, REQ_PLUS and REQ_MINUS and acts only on 0->1
//    transitions. A request held high for many clocks counts once.
//  - Set: a REQ_PLUS[i] rise sets pend_p[i]; a REQ_MINUS[i] rise sets pend_m[i].
//  - Cancel: if pend_p[i] and pend_m[i] would both be set after an update, both clear.
//    No grant is issued and CNT_LOST stays 0 (net zero).
//  - Lost request: a rise on a bit that is already 1 leaves the bit at 1 and pulses CNT_LOST for one clock.
//  - Schedule: on the clock after a T12 rise is detected (latency 1 from the T12 edge):
//      * grant <= lowest i with pend_p[i]|pend_m[i], provided STOP=0 and GOJAM=0;
//      * otherwise grant <= 0;
//      * the winner's pending bit clears in that same clock;
//      * CNT_DIR <= pend_m[winner].
//  - Grant lifetime: the grant holds constant for the whole following MCT until the next
//    T12 rise, then is replaced by the next winner or by 0.
//  - Same-clock set and clear: if the winner bit is cleared and a new rise for that cell and
//    direction arrives in the same clock, set wins. The bit stays pending and is served in a later MCT.
//  - STOP=1: pending bits keep accumulating and cancelling; any existing grant drops to 0 at the next T12 rise.
//  - GOJAM=1: synchronously clears pending, grant and CNT_LOST every clock; request rises are ignored.
//    Scheduling resumes at the first T12 rise after GOJAM falls.
//  - SIM_RST mid-MCT: the grant drops on the next clock and the in-flight grant is discarded, not replayed.
//  - PEND_ANY excludes the currently granted cell once its bit has cleared.
// STRUCTURE
//  - Package cntr_sched_pkg holds:
//      * NCELLS and IDXW defaults;
//      * localparams for named cell indices (TIME1..TIME6, CDU, OPT, PIPA...);
//      * the direction encoding (DIR_PLUS=0, DIR_MINUS=1).
//  - One sub-module, cntr_prio_enc: combinational NCELLS-in lowest-index-first priority
//    encoder with outputs one-hot, binary index and valid.
//  - All state lives in this module: pend_p, pend_m, grant, dir, and the previous-value regs for T12 and REQ.
// TESTING
//  1. Reset: hold SIM_RST 3 clocks with REQ_PLUS=all-ones -> all outputs 0; no pending set on release without a fresh rise.
//  2. Single request:
//       - stimulus: REQ_PLUS[7] pulse, then T12 rise;
//       - response: CNT_GRANT=1<<7, CNT_IDX=7, CNT_DIR=0 one clock after the edge;
//       - it holds until the next T12 rise, then drops to 0 and PEND_ANY=0.
//  3. Priority:
//       - stimulus: REQ_MINUS[3], REQ_PLUS[0] and REQ_PLUS[12] rise together; three MCTs;
//       - response: grants in order idx 0 (DIR 0), idx 3 (DIR 1), idx 12 (DIR 0), then none.
//  4. Cancel and lost:
//       - REQ_PLUS[5] and REQ_MINUS[5] rise in the same clock -> no grant and CNT_LOST=0;
//       - two REQ_PLUS[2] rises before a T12 -> CNT_LOST pulses once and exactly one grant follows.
//  5. Set-wins collision: REQ_PLUS[4] rises in the clock its grant is latched -> idx 4 is granted in two consecutive MCTs.
//  6. STOP and GOJAM:
//       - STOP=1 across two T12 rises with REQ_PLUS[9] pending -> no grant and PEND_ANY=1;
//       - STOP=0 -> idx 9 is granted at the next T12;
//       - GOJAM pulse mid-MCT -> grant and pending are 0 on the next clock.

Source files
------------

// File: rtl/cntr_sched_pkg.sv
// Shared constants for the counter-request scheduler: sizing defaults, named cells, direction code.
// No logic, so no latency and no backpressure.
package cntr_sched_pkg;
    localparam int NCELLS_DFLT = 20;
    localparam int IDXW_DFLT   = 5;

    // Named counter cells; a lower index means a higher priority.
    localparam int CELL_OVCTR = 0;
    localparam int CELL_TIME2 = 1;
    localparam int CELL_TIME1 = 2;
    localparam int CELL_TIME3 = 3;
    localparam int CELL_TIME4 = 4;
    localparam int CELL_TIME5 = 5;
    localparam int CELL_TIME6 = 6;
    localparam int CELL_CDUX  = 7;
    localparam int CELL_CDUY  = 8;
    localparam int CELL_CDUZ  = 9;
    localparam int CELL_OPTY  = 10;
    localparam int CELL_OPTX  = 11;
    localparam int CELL_PIPAX = 12;
    localparam int CELL_PIPAY = 13;
    localparam int CELL_PIPAZ = 14;

    localparam logic DIR_PLUS  = 1'b0;
    localparam logic DIR_MINUS = 1'b1;
endpackage

// File: rtl/cntr_prio_enc.sv
// Lowest-index-first priority encoder producing one-hot, binary index and valid.
// Purely combinational, zero latency; it has no flow control of its own.
module cntr_prio_enc
    import cntr_sched_pkg::*;
#(
    parameter int N = NCELLS_DFLT,
    parameter int W = IDXW_DFLT
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         vld
);
    // Walk from the top down so the last hit, the lowest index, wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        vld    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = W'(i);
                vld       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cntr_req_sched.sv
// Latches PINC/MINC request edges per counter cell and grants the lowest pending cell once per MCT.
// The grant is registered on the clock that sees the T12 rise; STOP/GOJAM hold off grants, requests are never stalled.
module cntr_req_sched
    import cntr_sched_pkg::*;
#(
    parameter int NCELLS = NCELLS_DFLT,
    parameter int IDXW   = IDXW_DFLT
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              T12,
    input  logic              GOJAM,
    input  logic              STOP,
    input  logic [NCELLS-1:0] REQ_PLUS,
    input  logic [NCELLS-1:0] REQ_MINUS,
    output logic [NCELLS-1:0] CNT_GRANT,
    output logic [IDXW-1:0]   CNT_IDX,
    output logic              CNT_DIR,
    output logic              CNT_ACTIVE,
    output logic              PEND_ANY,
    output logic              CNT_LOST
);
    logic              t12_q;
    logic [NCELLS-1:0] req_p_q, req_m_q;
    logic [NCELLS-1:0] pend_p, pend_m;
    logic [NCELLS-1:0] grant;
    logic [IDXW-1:0]   grant_idx;
    logic              dir;
    logic              lost;

    logic              t12_rise;
    logic [NCELLS-1:0] rise_p, rise_m;
    logic [NCELLS-1:0] win_oh;
    logic [IDXW-1:0]   win_idx;
    logic              win_vld;
    logic              serve;
    logic [NCELLS-1:0] clr;
    logic [NCELLS-1:0] upd_p, upd_m, cancel;
    logic              lost_nxt;

    assign t12_rise = T12 & ~t12_q;
    assign rise_p   = REQ_PLUS & ~req_p_q;
    assign rise_m   = REQ_MINUS & ~req_m_q;

    cntr_prio_enc #(.N(NCELLS), .W(IDXW)) u_prio (
        .req    (pend_p | pend_m),
        .onehot (win_oh),
        .idx    (win_idx),
        .vld    (win_vld)
    );

    // The winner's bit clears before new rises are merged in, so a same-clock rise re-arms it.
    assign serve  = t12_rise & ~STOP & win_vld;
    assign clr    = serve ? win_oh : '0;
    assign upd_p  = (pend_p & ~clr) | rise_p;
    assign upd_m  = (pend_m & ~clr) | rise_m;
    assign cancel = upd_p & upd_m;

    // A repeated edge on an already-pending bit is dropped; cells that net to zero never report loss.
    assign lost_nxt = |(((rise_p & pend_p & ~clr) | (rise_m & pend_m & ~clr)) & ~cancel);

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            t12_q     <= 1'b0;
            req_p_q   <= '0;
            req_m_q   <= '0;
            pend_p    <= '0;
            pend_m    <= '0;
            grant     <= '0;
            grant_idx <= '0;
            dir       <= DIR_PLUS;
            lost      <= 1'b0;
        end else begin
            t12_q   <= T12;
            req_p_q <= REQ_PLUS;
            req_m_q <= REQ_MINUS;
            if (GOJAM) begin
                pend_p    <= '0;
                pend_m    <= '0;
                grant     <= '0;
                grant_idx <= '0;
                dir       <= DIR_PLUS;
                lost      <= 1'b0;
            end else begin
                pend_p <= upd_p & ~cancel;
                pend_m <= upd_m & ~cancel;
                lost   <= lost_nxt;
                if (t12_rise) begin
                    if (serve) begin
                        grant     <= win_oh;
                        grant_idx <= win_idx;
                        dir       <= (|(pend_m & win_oh)) ? DIR_MINUS : DIR_PLUS;
                    end else begin
                        grant     <= '0;
                        grant_idx <= '0;
                        dir       <= DIR_PLUS;
                    end
                end
            end
        end
    end

    assign CNT_GRANT  = grant;
    assign CNT_IDX    = grant_idx;
    assign CNT_DIR    = dir;
    assign CNT_ACTIVE = |grant;
    assign PEND_ANY   = |(pend_p | pend_m);
    assign CNT_LOST   = lost;
endmodule

// File: tb/tb_cntr_req_sched.sv
// Directed bench for cntr_req_sched: hand-computed expectations checked with immediate assertions.
module tb_cntr_req_sched;
    localparam int N = 20;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         t12, gojam, stop;
    logic [N-1:0] req_plus, req_minus;
    logic [N-1:0] cnt_grant;
    logic [W-1:0] cnt_idx;
    logic         cnt_dir, cnt_active, pend_any, cnt_lost;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cntr_req_sched #(.NCELLS(N), .IDXW(W)) dut (
        .SIM_CLK    (clk),
        .SIM_RST    (rst),
        .T12        (t12),
        .GOJAM      (gojam),
        .STOP       (stop),
        .REQ_PLUS   (req_plus),
        .REQ_MINUS  (req_minus),
        .CNT_GRANT  (cnt_grant),
        .CNT_IDX    (cnt_idx),
        .CNT_DIR    (cnt_dir),
        .CNT_ACTIVE (cnt_active),
        .PEND_ANY   (pend_any),
        .CNT_LOST   (cnt_lost)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the full grant bundle at once.
    task automatic chk_grant(input string tag, input bit act, input int idx, input bit d);
        logic [31:0] oh;
        oh = act ? (32'd1 << idx) : 32'd0;
        chk({tag, ".grant"}, 32'(cnt_grant), oh);
        chk({tag, ".idx"},   32'(cnt_idx), act ? 32'(idx) : 32'd0);
        chk({tag, ".active"}, 32'(cnt_active), 32'(act));
        if (act) chk({tag, ".dir"}, 32'(cnt_dir), 32'(d));
    endtask

    // Start a fresh MCT: T12 low for two clocks, then a rise; returns one clock after the rise is sampled.
    task automatic mct();
        t12 = 1'b0;
        tick();
        tick();
        t12 = 1'b1;
        tick();
    endtask

    task automatic pulse_plus(input int i);
        req_plus[i] = 1'b1;
        tick();
        req_plus[i] = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; t12 = 1'b0; gojam = 1'b0; stop = 1'b0;
        req_plus = '1; req_minus = '0;

        // 1. Reset
        tick(); tick(); tick();
        chk_grant("rst", 1'b0, 0, 1'b0);
        chk("rst.pend", 32'(pend_any), 32'd0);
        chk("rst.lost", 32'(cnt_lost), 32'd0);
        chk("rst.dir", 32'(cnt_dir), 32'd0);
        rst = 1'b0; req_plus = '0;
        tick(); tick();
        chk("rst.release_pend", 32'(pend_any), 32'd0);

        // 2. Single request
        pulse_plus(7);
        chk("single.pend_before", 32'(pend_any), 32'd1);
        t12 = 1'b1;
        tick();
        chk_grant("single.grant", 1'b1, 7, 1'b0);
        chk("single.pend_after", 32'(pend_any), 32'd0);
        t12 = 1'b0;
        tick(); tick(); tick();
        chk_grant("single.hold", 1'b1, 7, 1'b0);
        t12 = 1'b1;
        tick();
        chk_grant("single.drop", 1'b0, 0, 1'b0);
        chk("single.pend_end", 32'(pend_any), 32'd0);

        // 3. Priority
        req_minus[3] = 1'b1; req_plus[0] = 1'b1; req_plus[12] = 1'b1;
        tick();
        req_minus = '0; req_plus = '0;
        tick();
        mct(); chk_grant("prio.m1", 1'b1, 0, 1'b0);
        mct(); chk_grant("prio.m2", 1'b1, 3, 1'b1);
        mct(); chk_grant("prio.m3", 1'b1, 12, 1'b0);
        mct(); chk_grant("prio.m4", 1'b0, 0, 1'b0);

        // 4a. Cancel
        req_plus[5] = 1'b1; req_minus[5] = 1'b1;
        tick();
        chk("cancel.lost", 32'(cnt_lost), 32'd0);
        chk("cancel.pend", 32'(pend_any), 32'd0);
        req_plus = '0; req_minus = '0;
        tick();
        mct(); chk_grant("cancel.none", 1'b0, 0, 1'b0);

        // 4b. Lost request
        req_plus[2] = 1'b1;
        tick();
        chk("lost.first", 32'(cnt_lost), 32'd0);
        req_plus[2] = 1'b0;
        tick();
        req_plus[2] = 1'b1;
        tick();
        chk("lost.pulse", 32'(cnt_lost), 32'd1);
        req_plus[2] = 1'b0;
        tick();
        chk("lost.one_clock", 32'(cnt_lost), 32'd0);
        mct(); chk_grant("lost.grant", 1'b1, 2, 1'b0);
        mct(); chk_grant("lost.only_one", 1'b0, 0, 1'b0);

        // 5. Set-wins collision
        pulse_plus(4);
        t12 = 1'b0;
        tick();
        t12 = 1'b1; req_plus[4] = 1'b1;
        tick();
        chk_grant("setwin.first", 1'b1, 4, 1'b0);
        chk("setwin.pend", 32'(pend_any), 32'd1);
        chk("setwin.lost", 32'(cnt_lost), 32'd0);
        req_plus = '0;
        mct(); chk_grant("setwin.second", 1'b1, 4, 1'b0);
        mct(); chk_grant("setwin.done", 1'b0, 0, 1'b0);

        // 6. STOP and GOJAM
        pulse_plus(9);
        stop = 1'b1;
        mct(); chk_grant("stop.m1", 1'b0, 0, 1'b0);
        chk("stop.pend1", 32'(pend_any), 32'd1);
        mct(); chk_grant("stop.m2", 1'b0, 0, 1'b0);
        chk("stop.pend2", 32'(pend_any), 32'd1);
        stop = 1'b0;
        mct(); chk_grant("stop.release", 1'b1, 9, 1'b0);
        pulse_plus(1);
        chk("gojam.pend_before", 32'(pend_any), 32'd1);
        gojam = 1'b1;
        tick();
        chk_grant("gojam.grant", 1'b0, 0, 1'b0);
        chk("gojam.pend", 32'(pend_any), 32'd0);
        gojam = 1'b0;
        tick();
        mct(); chk_grant("gojam.after", 1'b0, 0, 1'b0);

        // Reset mid-MCT discards the in-flight grant
        pulse_plus(6);
        mct(); chk_grant("midrst.grant", 1'b1, 6, 1'b0);
        rst = 1'b1;
        tick();
        chk_grant("midrst.drop", 1'b0, 0, 1'b0);
        rst = 1'b0;
        mct(); chk_grant("midrst.no_replay", 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
